// File: rtl/st2_execute.sv
// rtl/st2_execute.sv - execute stage: 1-cycle ALU plus iterative (or barrel, with BARREL_SHIFT_EN) shifter
// Optional feature macro: BARREL_SHIFT_EN selects a single-cycle barrel shifter and removes the SHIFT state.
module st2_execute #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  aluin1,
    input  logic [DATA_W-1:0]  aluin2,
    input  logic [2:0]         operation_in,
    input  logic [2:0]         opselect_in,
    input  logic               enable_arith,
    input  logic               enable_shift,
    input  logic [SHAMT_W-1:0] shift_number,
    output logic               busy,
    output logic [DATA_W-1:0]  alu_result,
    output logic               result_valid,
    output logic [2:0]         opselect_out,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_ovf
);

    logic [DATA_W-1:0] res_q, res_d;
    logic              valid_q, valid_d;
    logic [2:0]        opsel_q, opsel_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W:0]   sum_add;
    logic [DATA_W:0]   sum_sub;
    logic [DATA_W-1:0] arith_res;
    logic              arith_carry;
    logic              arith_ovf;

    // SUB is A + ~B + 1 so bit DATA_W is the no-borrow indication
    assign sum_add = {1'b0, aluin1} + {1'b0, aluin2};
    assign sum_sub = {1'b0, aluin1} + {1'b0, ~aluin2} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        arith_res   = '0;
        arith_carry = 1'b0;
        arith_ovf   = 1'b0;
        case (operation_in)
            3'b000: begin
                arith_res   = sum_add[DATA_W-1:0];
                arith_carry = sum_add[DATA_W];
                arith_ovf   = (aluin1[DATA_W-1] == aluin2[DATA_W-1]) &&
                              (sum_add[DATA_W-1] != aluin1[DATA_W-1]);
            end
            3'b001: begin
                arith_res   = sum_sub[DATA_W-1:0];
                arith_carry = sum_sub[DATA_W];
                arith_ovf   = (aluin1[DATA_W-1] != aluin2[DATA_W-1]) &&
                              (sum_sub[DATA_W-1] != aluin1[DATA_W-1]);
            end
            3'b010:  arith_res = aluin1 & aluin2;
            3'b011:  arith_res = aluin1 | aluin2;
            3'b100:  arith_res = aluin1 ^ aluin2;
            3'b101:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
            3'b110:  arith_res = {{(DATA_W-1){1'b0}}, (aluin1 < aluin2)};
            default: arith_res = aluin2;
        endcase
    end

`ifdef BARREL_SHIFT_EN

    function automatic logic [DATA_W-1:0] barrel(input logic [DATA_W-1:0] v,
                                                 input logic [SHAMT_W-1:0] k,
                                                 input logic [1:0] mode);
        logic [2*DATA_W-1:0] dbl;
        dbl = {v, v} >> k;
        case (mode)
            2'b00:   return v << k;
            2'b01:   return v >> k;
            2'b10:   return $unsigned($signed(v) >>> k);
            default: return dbl[DATA_W-1:0];
        endcase
    endfunction

    logic [DATA_W-1:0] barrel_res;
    assign barrel_res = barrel(aluin1, shift_number, operation_in[1:0]);

    always_comb begin
        res_d   = res_q;
        valid_d = 1'b0;
        opsel_d = opsel_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (enable_shift) begin
            res_d   = barrel_res;
            valid_d = 1'b1;
            opsel_d = opselect_in;
            zero_d  = (barrel_res == '0);
            carry_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (enable_arith) begin
            res_d   = arith_res;
            valid_d = 1'b1;
            opsel_d = opselect_in;
            zero_d  = (arith_res == '0);
            carry_d = arith_carry;
            ovf_d   = arith_ovf;
        end
    end

    assign busy = 1'b0;

`else

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic               state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [2:0]         pend_q, pend_d;
    logic [DATA_W-1:0]  shifted;

    function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v,
                                                    input logic [1:0] mode);
        case (mode)
            2'b00:   return {v[DATA_W-2:0], 1'b0};
            2'b01:   return {1'b0, v[DATA_W-1:1]};
            2'b10:   return {v[DATA_W-1], v[DATA_W-1:1]};
            default: return {v[0], v[DATA_W-1:1]};
        endcase
    endfunction

    assign shifted = shift_one(acc_q, mode_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        res_d   = res_q;
        valid_d = 1'b0;
        opsel_d = opsel_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (state_q == ST_IDLE) begin
            if (enable_shift) begin
                if (shift_number == '0) begin
                    res_d   = aluin1;
                    valid_d = 1'b1;
                    opsel_d = opselect_in;
                    zero_d  = (aluin1 == '0);
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    acc_d   = aluin1;
                    cnt_d   = shift_number;
                    mode_d  = operation_in[1:0];
                    pend_d  = opselect_in;
                    state_d = ST_SHIFT;
                end
            end else if (enable_arith) begin
                res_d   = arith_res;
                valid_d = 1'b1;
                opsel_d = opselect_in;
                zero_d  = (arith_res == '0);
                carry_d = arith_carry;
                ovf_d   = arith_ovf;
            end
        end else begin
            acc_d = shifted;
            cnt_d = cnt_q - 1'b1;
            // Last step publishes the shifted value directly rather than waiting for acc_q
            if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                state_d = ST_IDLE;
                res_d   = shifted;
                valid_d = 1'b1;
                opsel_d = pend_q;
                zero_d  = (shifted == '0);
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);

`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
            opsel_q <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
            opsel_q <= opsel_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign alu_result   = res_q;
    assign result_valid = valid_q;
    assign opselect_out = opsel_q;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;
    assign flag_ovf     = ovf_q;

endmodule

// File: tb/tb_st2_execute.sv
// tb/tb_st2_execute.sv - directed self-checking bench for st2_execute
module tb_st2_execute;

    logic        clk;
    logic        reset_n;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [2:0]  operation_in;
    logic [2:0]  opselect_in;
    logic        enable_arith;
    logic        enable_shift;
    logic [4:0]  shift_number;
    logic        busy;
    logic [31:0] alu_result;
    logic        result_valid;
    logic [2:0]  opselect_out;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_ovf;

    int errors = 0;
    int checks = 0;

`ifdef BARREL_SHIFT_EN
    localparam bit ITER = 1'b0;
`else
    localparam bit ITER = 1'b1;
`endif

    st2_execute dut (
        .clk(clk), .reset_n(reset_n), .aluin1(aluin1), .aluin2(aluin2),
        .operation_in(operation_in), .opselect_in(opselect_in),
        .enable_arith(enable_arith), .enable_shift(enable_shift),
        .shift_number(shift_number), .busy(busy), .alu_result(alu_result),
        .result_valid(result_valid), .opselect_out(opselect_out),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable_arith = 1'b0;
        enable_shift = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        aluin1 = 32'hFFFF_FFFF; aluin2 = 32'h1; operation_in = 3'b000;
        opselect_in = 3'b111; shift_number = 5'd0;
        tick(); tick();
        checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", alu_result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({opselect_out, flag_zero, flag_carry, flag_ovf} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=000000", {opselect_out, flag_zero, flag_carry, flag_ovf});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_arith();
        logic [2:0]  t_op  [11] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        logic [31:0] t_a   [11] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                    32'h1, 32'h5, 32'hF0F0_FF00, 32'hF0F0_FF00, 32'hF0F0_FF00, 32'h1234_5678};
        logic [31:0] t_b   [11] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h2, 32'h5,
                                    32'h0FF0_F0F0, 32'h0FF0_F0F0, 32'h0FF0_F0F0, 32'hDEAD_BEEF};
        logic [31:0] t_res [11] = '{32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,
                                    32'h00F0_F000, 32'hFFF0_FFF0, 32'hFF00_0FF0, 32'hDEAD_BEEF};
        logic [2:0]  t_zcv [11] = '{3'b110, 3'b011, 3'b000, 3'b100, 3'b001, 3'b000, 3'b110,
                                    3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 11; i++) begin
            aluin1 = t_a[i]; aluin2 = t_b[i]; operation_in = t_op[i];
            opselect_in = 3'(i); enable_arith = 1'b1; enable_shift = 1'b0;
            tick();
            checks++; if (alu_result !== t_res[i]) begin errors++; $display("FAIL arith%0d_result got=%h exp=%h", i, alu_result, t_res[i]); end
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_valid got=%b exp=1", i, result_valid); end
            checks++; if ({flag_zero, flag_carry, flag_ovf} !== t_zcv[i]) begin
                errors++; $display("FAIL arith%0d_zcv got=%b exp=%b", i, {flag_zero, flag_carry, flag_ovf}, t_zcv[i]);
            end
            checks++; if (opselect_out !== 3'(i)) begin errors++; $display("FAIL arith%0d_opsel got=%0d exp=%0d", i, opselect_out, i); end
        end
        idle_inputs();
        aluin2 = 32'h0;
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL arith_valid_drop got=%b exp=0", result_valid); end
        checks++; if (alu_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL arith_hold got=%h exp=deadbeef", alu_result); end
    endtask

    task automatic run_shift(input string name, input logic [31:0] a, input logic [2:0] op,
                             input logic [4:0] k, input logic both, input logic [31:0] exp);
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_lat = ITER ? int'(k) : 0;
        aluin1 = a; aluin2 = 32'h5; operation_in = op; shift_number = k;
        opselect_in = 3'b101; enable_shift = 1'b1; enable_arith = both;
        tick();
        idle_inputs();
        lat = 0; busy_cnt = 0;
        while (result_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        checks++; if (alu_result !== exp) begin errors++; $display("FAIL %s_result got=%h exp=%h", name, alu_result, exp); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
        checks++; if (busy_cnt != exp_lat) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, busy_cnt, exp_lat); end
        checks++; if ({busy, flag_zero, flag_carry, flag_ovf} !== {1'b0, exp == 32'h0, 2'b00}) begin
            errors++; $display("FAIL %s_flags got=%b exp=%b", name, {busy, flag_zero, flag_carry, flag_ovf}, {1'b0, exp == 32'h0, 2'b00});
        end
        checks++; if (opselect_out !== 3'b101) begin errors++; $display("FAIL %s_opsel got=%0d exp=5", name, opselect_out); end
        tick();
        checks++; if (result_valid !== 1'b0 || alu_result !== exp) begin
            errors++; $display("FAIL %s_after got=%b/%h exp=0/%h", name, result_valid, alu_result, exp);
        end
    endtask

    task automatic test_shift();
        run_shift("sra4",   32'h8000_0010, 3'b010, 5'd4,  1'b0, 32'hF800_0001);
        run_shift("sll0",   32'h0000_1234, 3'b000, 5'd0,  1'b0, 32'h0000_1234);
        run_shift("ror1",   32'h0000_0001, 3'b011, 5'd1,  1'b0, 32'h8000_0000);
        run_shift("sll31",  32'h0000_0001, 3'b000, 5'd31, 1'b0, 32'h8000_0000);
        run_shift("srl31",  32'h8000_0000, 3'b001, 5'd31, 1'b0, 32'h0000_0001);
        run_shift("sllzero",32'h8000_0000, 3'b000, 5'd1,  1'b0, 32'h0000_0000);
        run_shift("sra_b2", 32'h8000_0000, 3'b110, 5'd1,  1'b0, 32'hC000_0000);
    endtask

    task automatic test_both_enables();
        run_shift("both", 32'h0000_0010, 3'b001, 5'd4, 1'b1, 32'h0000_0001);
    endtask

    task automatic test_busy_ignore();
        int lat;
        if (ITER) begin
            aluin1 = 32'h1; operation_in = 3'b000; shift_number = 5'd8; opselect_in = 3'b010;
            enable_shift = 1'b1; enable_arith = 1'b0;
            tick();
            enable_shift = 1'b0; enable_arith = 1'b1; aluin1 = 32'h2; aluin2 = 32'h3;
            lat = 0;
            while (result_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
            idle_inputs();
            checks++; if (alu_result !== 32'h100 || lat != 8) begin
                errors++; $display("FAIL busy_ignore_result got=%h lat=%0d exp=00000100 lat=8", alu_result, lat);
            end
            tick();
            checks++; if (result_valid !== 1'b0 || alu_result !== 32'h100) begin
                errors++; $display("FAIL busy_ignore_no_add got=%b/%h exp=0/00000100", result_valid, alu_result);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        aluin1 = 32'h1; operation_in = 3'b000; shift_number = 5'd2; opselect_in = 3'b001;
        enable_shift = 1'b1; enable_arith = 1'b0;
        tick();
        enable_shift = 1'b0; enable_arith = 1'b1; aluin1 = 32'h2; aluin2 = 32'h3;
        operation_in = 3'b000; opselect_in = 3'b011;
        lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++; if (alu_result !== 32'h4 || lat != (ITER ? 2 : 0)) begin
            errors++; $display("FAIL b2b_shift got=%h lat=%0d exp=00000004 lat=%0d", alu_result, lat, ITER ? 2 : 0);
        end
        tick();
        idle_inputs();
        checks++; if (result_valid !== 1'b1 || alu_result !== 32'h5 || opselect_out !== 3'b011) begin
            errors++; $display("FAIL b2b_add got=%b/%h/%0d exp=1/00000005/3", result_valid, alu_result, opselect_out);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        aluin1 = 32'h1; operation_in = 3'b000; shift_number = 5'd8; opselect_in = 3'b110;
        enable_shift = 1'b1; enable_arith = 1'b0;
        tick();
        idle_inputs();
        tick(); tick();
        reset_n = 1'b0;
        tick();
        checks++; if ({busy, result_valid, alu_result} !== 34'h0) begin
            errors++; $display("FAIL midreset_outputs got=%b/%b/%h exp=0/0/0", busy, result_valid, alu_result);
        end
        checks++; if ({opselect_out, flag_zero, flag_carry, flag_ovf} !== 6'b0) begin
            errors++; $display("FAIL midreset_flags got=%b exp=000000", {opselect_out, flag_zero, flag_carry, flag_ovf});
        end
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_stale got=%0d exp=0", seen); end
        aluin1 = 32'h2; aluin2 = 32'h3; operation_in = 3'b000; opselect_in = 3'b100; enable_arith = 1'b1;
        tick();
        idle_inputs();
        checks++; if (result_valid !== 1'b1 || alu_result !== 32'h5 || flag_zero !== 1'b0) begin
            errors++; $display("FAIL midreset_add got=%b/%h/%b exp=1/00000005/0", result_valid, alu_result, flag_zero);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_both_enables();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
